// File: rtl/ef_adc_sar_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ef_adc_sar_seq_ctrl
// Brief    : SAR ADC conversion sequencer. Walks a programmable channel
//            sequence, runs the bit-serial SAR search against the analog
//            macro, averages 2^k conversions and queues tagged results in a
//            first-word-fall-through FIFO with a window-comparator flag.
// Revision : 1.0 - initial release
// ============================================================================
module ef_adc_sar_seq_ctrl #(
  parameter int RES        = 10,
  parameter int NCH        = 8,
  parameter int SEQ_DEPTH  = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int SW  = $clog2(SEQ_DEPTH),
  localparam int FW  = $clog2(FIFO_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic                     cont,
  input  logic [SW-1:0]            seq_len,
  input  logic [SEQ_DEPTH*CHW-1:0] seq_chans,
  input  logic [7:0]               sample_cycles,
  input  logic [1:0]               avg_log2,
  input  logic [RES-1:0]           win_lo,
  input  logic [RES-1:0]           win_hi,
  input  logic                     cmp,
  output logic                     sample_n,
  output logic [CHW-1:0]           ch_sel_out,
  output logic [RES-1:0]           adc_data,
  output logic                     dac_rst,
  output logic                     adc_en,
  output logic                     busy,
  input  logic                     fifo_rd,
  output logic [CHW+RES-1:0]       fifo_rdata,
  output logic [FW:0]              fifo_level,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     fifo_ovf,
  output logic                     seq_done,
  output logic                     win_hit
);

  localparam int              CBW      = $clog2(RES);
  localparam int              AW       = RES + 3;
  localparam logic [FW:0]     FULL_LVL = FIFO_DEPTH[FW:0];
  localparam logic [RES-1:0]  MSB_TRY  = {1'b1, {(RES-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAMPLE  = 3'd1,
    S_CONVERT = 3'd2,
    S_ACC     = 3'd3,
    S_STORE   = 3'd4
  } state_t;

  state_t              state;
  logic [SW-1:0]       slot;
  logic [SW-1:0]       last_slot;
  logic [7:0]          samp_cnt;
  logic [7:0]          samp_load;
  logic [CBW-1:0]      bit_idx;
  logic [AW-1:0]       acc;
  logic [2:0]          conv_cnt;
  logic [2:0]          avg_last;
  logic [RES-1:0]      result;
  logic [CHW-1:0]      chan_tab [SEQ_DEPTH];
  logic                push;
  logic [CHW+RES-1:0]  push_data;

  // Unpack the flat per-slot channel bus into an indexable table
  for (genvar i = 0; i < SEQ_DEPTH; i++) begin : g_chan
    assign chan_tab[i] = seq_chans[i*CHW +: CHW];
  end

  // Slot indices that cannot address a real slot are pulled back to the last one
  if ((1 << SW) == SEQ_DEPTH) begin : g_len_pow2
    assign last_slot = seq_len;
  end else begin : g_len_clamp
    assign last_slot = (seq_len > SW'(SEQ_DEPTH - 1)) ? SW'(SEQ_DEPTH - 1) : seq_len;
  end

  // Counter reload holds one less than the sample length; zero means one cycle
  assign samp_load = (sample_cycles == 8'd0) ? 8'd0 : sample_cycles - 8'd1;
  assign avg_last  = 3'((4'd1 << avg_log2) - 4'd1);
  assign result    = RES'(acc >> avg_log2);
  assign push      = (state == S_STORE) && en;
  assign push_data = {ch_sel_out, result};
  assign adc_en    = en;
  assign busy      = (state != S_IDLE);

  // Sequencer: sample, SAR search, accumulate, store; en low aborts to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      slot       <= '0;
      samp_cnt   <= '0;
      bit_idx    <= '0;
      acc        <= '0;
      conv_cnt   <= '0;
      sample_n   <= 1'b1;
      dac_rst    <= 1'b0;
      adc_data   <= '0;
      ch_sel_out <= '0;
      seq_done   <= 1'b0;
      win_hit    <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      win_hit  <= 1'b0;
      if (!en) begin
        state    <= S_IDLE;
        slot     <= '0;
        acc      <= '0;
        conv_cnt <= '0;
        sample_n <= 1'b1;
        dac_rst  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_SAMPLE;
              slot       <= '0;
              sample_n   <= 1'b0;
              dac_rst    <= 1'b1;
              ch_sel_out <= chan_tab[0];
              samp_cnt   <= samp_load;
            end
          end
          S_SAMPLE: begin
            if (samp_cnt == 8'd0) begin
              state    <= S_CONVERT;
              sample_n <= 1'b1;
              dac_rst  <= 1'b0;
              adc_data <= MSB_TRY;
              bit_idx  <= CBW'(RES - 1);
            end else begin
              samp_cnt <= samp_cnt - 8'd1;
            end
          end
          S_CONVERT: begin
            // Keep the trial bit only if vin is at or above the trial code
            adc_data[bit_idx] <= cmp;
            if (bit_idx != '0) begin
              adc_data[bit_idx - 1'b1] <= 1'b1;
              bit_idx                  <= bit_idx - 1'b1;
            end else begin
              state <= S_ACC;
            end
          end
          S_ACC: begin
            acc <= acc + AW'(adc_data);
            if (conv_cnt < avg_last) begin
              conv_cnt   <= conv_cnt + 3'd1;
              state      <= S_SAMPLE;
              sample_n   <= 1'b0;
              dac_rst    <= 1'b1;
              ch_sel_out <= chan_tab[slot];
              samp_cnt   <= samp_load;
            end else begin
              state <= S_STORE;
            end
          end
          S_STORE: begin
            acc      <= '0;
            conv_cnt <= '0;
            win_hit  <= (result < win_lo) || (result > win_hi);
            if (slot == last_slot) begin
              seq_done <= 1'b1;
              slot     <= '0;
              if (cont) begin
                state      <= S_SAMPLE;
                sample_n   <= 1'b0;
                dac_rst    <= 1'b1;
                ch_sel_out <= chan_tab[0];
                samp_cnt   <= samp_load;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              slot       <= slot + 1'b1;
              state      <= S_SAMPLE;
              sample_n   <= 1'b0;
              dac_rst    <= 1'b1;
              ch_sel_out <= chan_tab[slot + 1'b1];
              samp_cnt   <= samp_load;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [CHW+RES-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0]      wr_ptr;
  logic [FW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == FULL_LVL);
  assign do_pop     = fifo_rd && !fifo_empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts
  assign do_push    = push && (!fifo_full || do_pop);
  assign fifo_rdata = fifo_empty ? '0 : mem[rd_ptr];

  // Storage array carries no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      fifo_ovf   <= 1'b0;
    end else begin
      fifo_ovf <= push && fifo_full && !do_pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ef_adc_sar_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ef_adc_sar_seq_ctrl
// Brief    : Self-checking bench for the SAR sequencer. An ideal comparator
//            drives cmp from a per-conversion input code table; a behavioural
//            model predicts FIFO contents, window flags and sequence latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ef_adc_sar_seq_ctrl;

  localparam int RES        = 10;
  localparam int NCH        = 8;
  localparam int SEQ_DEPTH  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int CHW        = 3;
  localparam int SW         = 3;
  localparam int FW         = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic                     start;
  logic                     cont;
  logic [SW-1:0]            seq_len;
  logic [SEQ_DEPTH*CHW-1:0] seq_chans;
  logic [7:0]               sample_cycles;
  logic [1:0]               avg_log2;
  logic [RES-1:0]           win_lo;
  logic [RES-1:0]           win_hi;
  logic                     cmp;
  logic                     sample_n;
  logic [CHW-1:0]           ch_sel_out;
  logic [RES-1:0]           adc_data;
  logic                     dac_rst;
  logic                     adc_en;
  logic                     busy;
  logic                     fifo_rd;
  logic [CHW+RES-1:0]       fifo_rdata;
  logic [FW:0]              fifo_level;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     fifo_ovf;
  logic                     seq_done;
  logic                     win_hit;

  always #5 clk = ~clk;

  ef_adc_sar_seq_ctrl #(
    .RES(RES), .NCH(NCH), .SEQ_DEPTH(SEQ_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont),
    .seq_len(seq_len), .seq_chans(seq_chans), .sample_cycles(sample_cycles),
    .avg_log2(avg_log2), .win_lo(win_lo), .win_hi(win_hi), .cmp(cmp),
    .sample_n(sample_n), .ch_sel_out(ch_sel_out), .adc_data(adc_data),
    .dac_rst(dac_rst), .adc_en(adc_en), .busy(busy), .fifo_rd(fifo_rd),
    .fifo_rdata(fifo_rdata), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_ovf(fifo_ovf), .seq_done(seq_done),
    .win_hit(win_hit)
  );

  // Ideal analog side: each SAMPLE phase picks up the next input code
  logic [RES-1:0] vin_code;
  logic [RES-1:0] vin_tab [64];
  int             conv_idx    = 0;
  int             samp_phases = 0;
  int             conv_base   = 0;

  assign cmp = (vin_code >= adc_data);

  always @(negedge sample_n) begin
    vin_code = vin_tab[(conv_idx - conv_base) & 63];
    conv_idx++;
    samp_phases++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: per slot, average 2^k ideal conversions (floor division)
  logic [CHW-1:0] ch_cfg [SEQ_DEPTH];
  int             exp_q[$];
  int             exp_cycles;
  logic [7:0]     exp_hits;

  task automatic build_model();
    int k;
    int navg;
    int sum;
    int r;
    int slen;
    exp_q.delete();
    exp_hits   = '0;
    k          = 0;
    navg       = 1 << avg_log2;
    slen       = (sample_cycles == 8'd0) ? 1 : int'(sample_cycles);
    exp_cycles = 1;
    for (int s = 0; s <= int'(seq_len); s++) begin
      sum = 0;
      for (int j = 0; j < navg; j++) begin
        sum += int'(vin_tab[k]);
        k++;
      end
      r = sum / navg;
      exp_q.push_back((int'(ch_cfg[s]) << RES) | r);
      if (r < int'(win_lo) || r > int'(win_hi)) exp_hits[s] = 1'b1;
      exp_cycles += navg * (slen + RES + 1) + 1;
    end
  endtask

  task automatic pack_chans();
    for (int i = 0; i < SEQ_DEPTH; i++) seq_chans[i*CHW +: CHW] = ch_cfg[i];
  endtask

  // Launch one non-continuous sequence (FIFO empty) and check timing and flags
  task automatic run_seq(input string tag);
    int         n;
    int         stores;
    int         prev_lvl;
    logic [7:0] hits;
    logic       done;
    pack_chans();
    build_model();
    conv_base = conv_idx;
    @(negedge clk);
    start    = 1'b1;
    n        = 0;
    stores   = 0;
    hits     = '0;
    prev_lvl = int'(fifo_level);
    done     = 1'b0;
    while (!done && n < 5000) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (int'(fifo_level) != prev_lvl) begin
        if (stores < 8) hits[stores] = win_hit;
        stores++;
        prev_lvl = int'(fifo_level);
      end
      if (seq_done) done = 1'b1;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_winhit"}, hits, exp_hits);
    check({tag, "_level"}, fifo_level, exp_q.size());
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic drain_check(input string tag);
    int i = 0;
    while (exp_q.size() > 0) begin
      check($sformatf("%s_e%0d", tag, i), fifo_rdata, exp_q.pop_front());
      fifo_rd = 1'b1;
      @(negedge clk);
      fifo_rd = 1'b0;
      i++;
    end
    check({tag, "_empty"}, fifo_empty, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sample_n"}, sample_n, 1);
    check({tag, "_dac_rst"}, dac_rst, 0);
    check({tag, "_adc_data"}, adc_data, 0);
    check({tag, "_ch_sel"}, ch_sel_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_empty"}, fifo_empty, 1);
    check({tag, "_rdata"}, fifo_rdata, 0);
    check({tag, "_pulses"}, {fifo_ovf, seq_done, win_hit}, 0);
  endtask

  initial begin
    int ph0;
    int ovf_cnt;
    int dn;
    int t;
    logic [CHW+RES-1:0] head;

    rst = 1'b1; en = 1'b1; start = 1'b0; cont = 1'b0; fifo_rd = 1'b0;
    seq_len = '0; seq_chans = '0; sample_cycles = 8'd4; avg_log2 = 2'd0;
    win_lo = '0; win_hi = '1;
    for (int i = 0; i < SEQ_DEPTH; i++) ch_cfg[i] = '0;
    for (int i = 0; i < 64; i++) vin_tab[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    check("adc_en_hi", adc_en, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single slot, channel 3, code 0x2A5
    ch_cfg[0] = 3'd3; vin_tab[0] = 10'h2A5;
    run_seq("single");
    check("single_head", fifo_rdata, {3'd3, 10'h2A5});
    fifo_rd = 1'b1; @(negedge clk); fifo_rd = 1'b0;
    fifo_rd = 1'b1; @(negedge clk); fifo_rd = 1'b0;
    check("rd_on_empty_level", fifo_level, 0);

    // Four slots in order
    seq_len = 3'd3;
    for (int i = 0; i < 4; i++) begin
      ch_cfg[i]  = CHW'(i);
      vin_tab[i] = RES'((i + 1) * 128);
    end
    run_seq("seq4");
    drain_check("seq4");

    // Averaging over four conversions
    seq_len = 3'd0; avg_log2 = 2'd2; ch_cfg[0] = 3'd6;
    vin_tab[0] = 10'd100; vin_tab[1] = 10'd101; vin_tab[2] = 10'd102; vin_tab[3] = 10'd104;
    ph0 = samp_phases;
    run_seq("avg4");
    check("avg4_phases", samp_phases - ph0, 4);
    drain_check("avg4");

    // Window comparator edges
    avg_log2 = 2'd0; seq_len = 3'd3; win_lo = 10'h100; win_hi = 10'h300;
    vin_tab[0] = 10'h0FF; vin_tab[1] = 10'h100; vin_tab[2] = 10'h300; vin_tab[3] = 10'h301;
    run_seq("win");
    drain_check("win");

    // Randomised configurations
    for (int it = 0; it < 6; it++) begin
      seq_len       = SW'($urandom_range(0, 7));
      avg_log2      = 2'($urandom_range(0, 3));
      sample_cycles = 8'($urandom_range(0, 5));
      win_lo        = RES'($urandom_range(0, 600));
      win_hi        = RES'(int'(win_lo) + $urandom_range(0, 400));
      for (int i = 0; i < SEQ_DEPTH; i++) ch_cfg[i] = CHW'($urandom_range(0, 7));
      for (int i = 0; i < 64; i++) vin_tab[i] = RES'($urandom_range(0, 1023));
      run_seq($sformatf("rnd%0d", it));
      drain_check($sformatf("rnd%0d", it));
    end

    // Continuous mode overflow
    seq_len = 3'd0; avg_log2 = 2'd0; sample_cycles = 8'd1; cont = 1'b1;
    ch_cfg[0] = 3'd5; pack_chans();
    for (int i = 0; i < 64; i++) vin_tab[i] = RES'($urandom_range(0, 1023));
    conv_base = conv_idx;
    @(negedge clk); start = 1'b1;
    t = 0;
    do begin @(negedge clk); start = 1'b0; t++; end while (fifo_level != 5'd16 && t < 2000);
    check("ovf_fill", fifo_level, 16);
    head = {3'd5, vin_tab[0]};
    check("ovf_head0", fifo_rdata, head);
    ovf_cnt = 0; dn = 0; t = 0;
    while (dn < 3 && t < 200) begin
      @(negedge clk); t++;
      if (seq_done) dn++;
      if (fifo_ovf) ovf_cnt++;
    end
    check("ovf_pulses", ovf_cnt, 3);
    check("ovf_level", fifo_level, 16);
    check("ovf_head1", fifo_rdata, head);
    repeat (12) @(negedge clk);
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
    check("rdwr_align", seq_done, 1);
    check("rdwr_no_ovf", fifo_ovf, 0);
    check("rdwr_level", fifo_level, 16);
    check("rdwr_head", fifo_rdata, {3'd5, vin_tab[1]});
    en = 1'b0; cont = 1'b0;
    @(negedge clk);
    check("ovf_abort_busy", busy, 0);
    en = 1'b1;
    fifo_rd = 1'b1;
    repeat (16) @(negedge clk);
    fifo_rd = 1'b0;
    check("ovf_drained", fifo_level, 0);

    // Abort mid-conversion
    sample_cycles = 8'd4; ch_cfg[0] = 3'd2; pack_chans(); vin_tab[0] = 10'h155;
    conv_base = conv_idx;
    @(negedge clk); start = 1'b1;
    t = 0;
    do begin @(negedge clk); start = 1'b0; t++; end while (sample_n != 1'b0 && t < 50);
    do begin @(negedge clk); t++; end while (sample_n != 1'b1 && t < 50);
    repeat (3) @(negedge clk);
    check("abort_in_conv", busy, 1);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_sample_n", sample_n, 1);
    check("abort_dac_rst", dac_rst, 0);
    check("abort_adc_en", adc_en, 0);
    en = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_push", fifo_level, 0);
    vin_tab[0] = 10'h0C3;
    run_seq("after_abort");
    check("after_abort_head", fifo_rdata, {3'd2, 10'h0C3});

    // Reset mid-sequence with a result still queued
    seq_len = 3'd3; pack_chans();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ef_adc_sar_seq_ctrl.md
Name: ef_adc_sar_seq_ctrl

Overview:
Parametrised SAR ADC conversion sequencer core, the next generation of the fixed 10-bit/8-channel controller. It drives the analog SAR macro (HOLD, channel select, DAC reset, SAR trial code, EN) and reads its comparator. Results go through an optional 2^k hardware averager into a first-word-fall-through result FIFO, with a window-comparator flag. The bus wrapper (APB/AHB/WB) sits above it and maps its inputs to registers.

Parameters:
RES, 10, SAR resolution in bits
NCH, 8, analog channel count; CHW = max(1, clog2(NCH))
SEQ_DEPTH, 8, sequence slots; SW = clog2(SEQ_DEPTH)
FIFO_DEPTH, 16, result FIFO entries (power of 2); FW = clog2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  controller enable; low aborts
start  in  1  one-cycle start-of-conversion pulse
cont  in  1  1 = restart sequence after last slot
seq_len  in  SW  last slot index (slots 0..seq_len run)
seq_chans  in  SEQ_DEPTH*CHW  channel per slot, slot i at [i*CHW +: CHW]
sample_cycles  in  8  HOLD-low duration in clk (0 treated as 1)
avg_log2  in  2  average over 1/2/4/8 conversions
win_lo, win_hi  in  RES each  window comparator bounds
cmp  in  1  comparator: 1 = vin >= DAC(adc_data)
sample_n  out  1  HOLD to macro; 0 = sampling
ch_sel_out  out  CHW  channel to macro
adc_data  out  RES  SAR trial code to DAC
dac_rst  out  1  DAC reset during sampling
adc_en  out  1  macro enable, equals en
busy  out  1  state != IDLE
fifo_rd  in  1  pop request
fifo_rdata  out  CHW+RES  {channel, result}, head entry
fifo_level  out  FW+1  entries held
fifo_empty, fifo_full  out  1  status
fifo_ovf  out  1  one-cycle pulse, result dropped
seq_done  out  1  one-cycle pulse, last slot stored
win_hit  out  1  one-cycle pulse, stored result outside [win_lo, win_hi]

Behaviour:
- Reset: state IDLE, sample_n=1, dac_rst=0, adc_data=0, ch_sel_out=0, busy=0, FIFO empty (level 0, rdata 0), all pulses 0, slot=0, accumulator 0.
- States: IDLE, SAMPLE, CONVERT, ACC, STORE.
- IDLE: start & en -> SAMPLE next cycle, slot=0. start while busy is ignored.
- SAMPLE: sample_n=0, dac_rst=1, ch_sel_out=seq_chans[slot]; lasts max(sample_cycles,1) cycles -> CONVERT.
- CONVERT: exactly RES cycles; sample_n=1, dac_rst=0. adc_data loads 1<<(RES-1) on entry. Each cycle, for trial bit b: if cmp==0, clear b; if b>0, set b-1. Final code is valid on ACC entry.
- ACC (1 cycle): acc += adc_data (width RES+3). If conv_cnt < 2^avg_log2 - 1: conv_cnt++ and go to SAMPLE with the same slot. Otherwise -> STORE.
- STORE (1 cycle): result = acc >> avg_log2 (truncate). Push {ch, result}. win_hit = (result < win_lo) | (result > win_hi). Clear acc and conv_cnt.
  - If slot == seq_len: seq_done pulse, slot=0, go to SAMPLE if cont else IDLE.
  - Otherwise: slot++, go to SAMPLE.
- ch_sel_out holds its value through CONVERT. The channel changes only on SAMPLE entry.
- seq_len > SEQ_DEPTH-1 is clamped to SEQ_DEPTH-1.
- en low in any state: IDLE next cycle. Partial accumulation is discarded and nothing is pushed. FIFO contents are kept. sample_n=1, dac_rst=0.
- FIFO:
  - fifo_rdata = mem[rd_ptr] combinationally; pointers wrap modulo FIFO_DEPTH.
  - Pop when fifo_rd & !empty; fifo_rd on empty is ignored.
  - Push when full and no pop: drop the entry, pulse fifo_ovf, level unchanged.
  - Push and pop in the same cycle while full: both proceed, level stays FIFO_DEPTH, no ovf.
  - Push and pop on empty: push only.
- Rising edge of rst mid-conversion: full reset on the next clk edge.

Test Plan:
- RES=10, bench comparator cmp=(vin_code >= adc_data), vin_code=0x2A5, seq_len=0, ch 3, avg_log2=0, sample_cycles=4, start -> after 4+10+1+1 cycles one FIFO entry {3,0x2A5}, seq_done pulse, busy back to 0.
- Sequence of 4 slots with channels 0,1,2,3 and codes 0x080/0x100/0x180/0x200 -> FIFO holds 4 entries in slot order, with matching channel tags.
- avg_log2=2 with per-conversion codes 100,101,102,104 -> single entry 101 (407>>2), 4 SAMPLE phases observed on sample_n.
- cont=1, FIFO_DEPTH=16, no reads -> level saturates at 16, fifo_ovf pulses once per further store, and the head entry is unchanged. A read on the same cycle as a push while full -> level stays 16 with no ovf.
- win_lo=0x100, win_hi=0x300, codes 0x0FF, 0x100, 0x300, 0x301 -> win_hit pulses on the first and last only.
- en dropped mid-CONVERT -> IDLE next cycle, no push, sample_n=1. A new start after en returns converts normally. Reset mid-sequence -> all outputs at reset values.
